// File: rtl/seq_shift_add_mul.sv
// Sequential shift-and-add multiplier with signed/unsigned operands.
// Radix-2 loop that skips zero operands and stops as soon as the multiplier is exhausted.
module seq_shift_add_mul #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic            smode_q, smode_d;
    logic [PW-1:0]   product_q, product_d;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [PW-1:0]    acc_step;
    logic [WIDTH-1:0] mplier_step;
    logic [CW-1:0]    cnt_step;
    logic             calc_last;

    // Most negative value negates onto itself, which is the correct unsigned magnitude.
    always_comb begin
        mag_a       = (signed_mode && a[WIDTH-1]) ? -a : a;
        mag_b       = (signed_mode && b[WIDTH-1]) ? -b : b;
        acc_step    = acc_q + (mplier_q[0] ? mcand_q : {PW{1'b0}});
        mplier_step = mplier_q >> 1;
        cnt_step    = cnt_q + CW'(1);
        calc_last   = (mplier_step == '0) || (cnt_step == CW'(WIDTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            smode_q   <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            smode_q   <= smode_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        smode_d   = smode_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    smode_d  = signed_mode;
                    if (a == '0 || b == '0) begin
                        state_d   = DONE;
                        product_d = '0;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_step;
                cnt_d    = cnt_step;
                if (calc_last) begin
                    state_d   = DONE;
                    product_d = (smode_q && neg_q && acc_step != '0) ? -acc_step : acc_step;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        product = product_q;
    end
endmodule
